// File: rtl/piezo_pkg.sv
// piezo_pkg: shared types and constants for the piezo tone/duration engine.
//   state_t          - top-level FSM state (IDLE / PLAY)
//   PER_W, DUR_W     - widths of the note period and note duration inputs
//   TICK_CLKS_DEFAULT- clocks per 1/100 s duration tick at 50 MHz
package piezo_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  localparam int PER_W             = 15;
  localparam int DUR_W             = 8;
  localparam int TICK_CLKS_DEFAULT = 500000;

endpackage

// File: rtl/dur_timer.sv
// dur_timer: note duration timing for piezo_drv.
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   clr        - high = hold all counters at 0 and suppress note_over
//   note_dur   - note duration in ticks (0 = never expires), used live
//   note_over  - registered one-cycle pulse, first cycle of the next note
//   restart    - combinational: this cycle is the last cycle of the note
// A tick is the wrap cycle of tick_cnt; dur_cnt counts ticks. When the last
// tick of the note wraps, all counters return to 0 in the same edge that
// raises note_over, so the pulse cycle is already cycle 0 of the next note.
module dur_timer
  import piezo_pkg::*;
#(
  parameter int TICK_CLKS = TICK_CLKS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [DUR_W-1:0] note_dur,
  output logic             note_over,
  output logic             restart
);

  // Keep a 1-bit counter even for TICK_CLKS == 1 so the vector is legal.
  localparam int            TW        = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CLKS - 1);

  logic [TW-1:0]    tick_cnt_reg;
  logic [DUR_W-1:0] dur_cnt_reg;
  logic             note_over_reg;

  logic tick_wrap;
  logic last_tick;

  assign tick_wrap = (tick_cnt_reg == TICK_LAST);
  // note_dur == 0 never matches, so the tone runs until clr.
  assign last_tick = (note_dur != '0) && (dur_cnt_reg == note_dur - 8'd1);
  // clr wins over a coincident end of note.
  assign restart   = !clr && tick_wrap && last_tick;
  assign note_over = note_over_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_reg  <= '0;
      dur_cnt_reg   <= '0;
      note_over_reg <= 1'b0;
    end else if (clr) begin
      tick_cnt_reg  <= '0;
      dur_cnt_reg   <= '0;
      note_over_reg <= 1'b0;
    end else begin
      note_over_reg <= restart;
      if (tick_wrap) begin
        tick_cnt_reg <= '0;
        dur_cnt_reg  <= last_tick ? '0 : dur_cnt_reg + 8'd1;
      end else begin
        tick_cnt_reg <= tick_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/piezo_drv.sv
// piezo_drv: tone/duration engine driving the complementary piezo pins.
//   clk        - 50 MHz system clock
//   rst_n      - asynchronous active-low reset
//   clr        - high = silence and hold all counters at 0
//   note_per   - square-wave full period in clocks (live, < 2 = silent)
//   note_dur   - note duration in ticks of TICK_CLKS clocks (live)
//   note_over  - one-cycle pulse when the current note duration expires
//   piezo      - square-wave drive, high for the first half of each period
//   piezo_n    - complement of piezo while playing, 0 when silent
// All outputs are registered; the first PLAY cycle follows the cycle in
// which clr is sampled low.
module piezo_drv
  import piezo_pkg::*;
#(
  parameter int TICK_CLKS = TICK_CLKS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [PER_W-1:0] note_per,
  input  logic [DUR_W-1:0] note_dur,
  output logic             note_over,
  output logic             piezo,
  output logic             piezo_n
);

  state_t           state_reg;
  logic [PER_W-1:0] freq_cnt_reg;
  logic             piezo_reg;
  logic             piezo_n_reg;

  logic playing;
  logic per_ok;
  logic high_half;
  logic hold;
  logic restart;

  assign playing   = (state_reg == PLAY) && !clr;
  assign per_ok    = (note_per >= 15'd2);
  assign high_half = (freq_cnt_reg < {1'b0, note_per[PER_W-1:1]});
  // Duration counters sit at 0 in IDLE, including the clr-low transition
  // cycle, so PLAY cycle 0 starts from a clean count.
  assign hold      = clr || (state_reg == IDLE);

  dur_timer #(
    .TICK_CLKS (TICK_CLKS)
  ) u_dur_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (hold),
    .note_dur  (note_dur),
    .note_over (note_over),
    .restart   (restart)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      freq_cnt_reg <= '0;
      piezo_reg    <= 1'b0;
      piezo_n_reg  <= 1'b0;
    end else begin
      state_reg <= clr ? IDLE : PLAY;
      // ">=" rather than "==" so a shortened period mid-note wraps at once.
      if (!playing || !per_ok || restart || (freq_cnt_reg >= note_per - 15'd1)) begin
        freq_cnt_reg <= '0;
      end else begin
        freq_cnt_reg <= freq_cnt_reg + 15'd1;
      end
      piezo_reg   <= playing && per_ok && high_half;
      piezo_n_reg <= playing && per_ok && !high_half;
    end
  end

  assign piezo   = piezo_reg;
  assign piezo_n = piezo_n_reg;

endmodule

// File: tb/tb_piezo_drv.sv
// tb_piezo_drv: self-checking bench for piezo_drv with TICK_CLKS = 10.
// A cycle-level reference model (elapsed cycles into the note, position in
// the tone period) predicts piezo, piezo_n and note_over after every edge.
module tb_piezo_drv;

  localparam int T = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [14:0] note_per;
  logic [7:0]  note_dur;
  logic        note_over;
  logic        piezo;
  logic        piezo_n;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit   m_play;
  int   m_n;
  int   m_p;
  logic e_p, e_pn, e_o;

  piezo_drv #(.TICK_CLKS(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .note_per  (note_per),
    .note_dur  (note_dur),
    .note_over (note_over),
    .piezo     (piezo),
    .piezo_n   (piezo_n)
  );

  always #5 clk = ~clk;

  // Advance one clock and update the expected outputs; returns 1 ns after the edge.
  task automatic cyc();
    int  per;
    bool_end: begin end
    @(posedge clk);
    per = int'(note_per);
    if (!rst_n) begin
      m_play = 0; m_n = 0; m_p = 0;
      e_p = 0; e_pn = 0; e_o = 0;
    end else if (!m_play) begin
      e_p = 0; e_pn = 0; e_o = 0;
      m_play = !clr; m_n = 0; m_p = 0;
    end else if (clr) begin
      e_p = 0; e_pn = 0; e_o = 0;
      m_play = 0; m_n = 0; m_p = 0;
    end else begin
      bit ok, done;
      ok   = (per >= 2);
      done = (note_dur != 0) && (m_n + 1 == int'(note_dur) * T);
      e_p  = ok && (m_p < per / 2);
      e_pn = ok && !(m_p < per / 2);
      e_o  = done;
      m_n  = done ? 0 : (m_n + 1) % (256 * T);
      m_p  = (!ok || done || m_p >= per - 1) ? 0 : m_p + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; clr = 0; note_per = 15'd8; note_dur = 8'd2;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if ({piezo, piezo_n, note_over} !== 3'b000) begin
        errors++;
        $display("FAIL reset cyc %0d: piezo/piezo_n/note_over=%b%b%b expected 000", i, piezo, piezo_n, note_over);
      end
    end
    clr = 1;
    @(negedge clk);
    rst_n = 1;
    cyc();
  endtask

  task automatic test_tone();
    int pulses[$];
    clr = 1; note_per = 15'd8; note_dur = 8'd3;
    cyc();
    clr = 0;
    for (int i = 1; i <= 65; i++) begin
      cyc();
      checks++;
      if ({piezo, piezo_n, note_over} !== {e_p, e_pn, e_o}) begin
        errors++;
        $display("FAIL tone cyc %0d: got piezo/piezo_n/note_over=%b%b%b expected %b%b%b", i - 1, piezo, piezo_n, note_over, e_p, e_pn, e_o);
      end
      if (note_over) pulses.push_back(i - 1);
    end
    checks++;
    if (pulses.size() != 2 || pulses[0] != 30 || pulses[1] != 60) begin
      errors++;
      $display("FAIL tone_pulses: got %0d pulses (first at %0d) expected 2 at 30 and 60", pulses.size(), (pulses.size() > 0) ? pulses[0] : -1);
    end
  endtask

  task automatic test_retune();
    int waited, gap;
    bit seen;
    clr = 1; note_per = 15'd8; note_dur = 8'd3;
    cyc();
    clr = 0;
    waited = 0;
    do begin
      cyc(); waited++;
    end while (!note_over && waited < 100);
    checks++;
    if (!note_over) begin
      errors++;
      $display("FAIL retune_first_pulse: note_over=%b after %0d cycles expected 1", note_over, waited);
    end
    cyc();
    note_per = 15'd6; note_dur = 8'd1;
    seen = 0; gap = 1;
    for (int i = 0; i < 25; i++) begin
      cyc(); gap++;
      checks++;
      if ({piezo, piezo_n, note_over} !== {e_p, e_pn, e_o}) begin
        errors++;
        $display("FAIL retune cyc %0d: got piezo/piezo_n/note_over=%b%b%b expected %b%b%b", i, piezo, piezo_n, note_over, e_p, e_pn, e_o);
      end
      if (note_over && !seen) begin
        seen = 1;
        checks++;
        if (gap != 10) begin
          errors++;
          $display("FAIL retune_gap: got %0d cycles between pulses expected 10", gap);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL retune_second_pulse: got no pulse expected one 10 cycles later");
    end
  endtask

  task automatic test_clr_mid();
    int first;
    clr = 1; note_per = 15'd8; note_dur = 8'd3;
    cyc();
    clr = 0;
    for (int i = 1; i <= 26; i++) cyc();
    clr = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if ({piezo, piezo_n, note_over} !== 3'b000) begin
        errors++;
        $display("FAIL clr_mid hold %0d: got piezo/piezo_n/note_over=%b%b%b expected 000", i, piezo, piezo_n, note_over);
      end
    end
    clr = 0;
    first = -1;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      checks++;
      if ({piezo, piezo_n, note_over} !== {e_p, e_pn, e_o}) begin
        errors++;
        $display("FAIL clr_mid cyc %0d: got piezo/piezo_n/note_over=%b%b%b expected %b%b%b", i - 1, piezo, piezo_n, note_over, e_p, e_pn, e_o);
      end
      if (note_over && first < 0) first = i - 1;
    end
    checks++;
    if (first != 30) begin
      errors++;
      $display("FAIL clr_mid_pulse: got first pulse at cycle %0d expected 30", first);
    end
  endtask

  task automatic test_short_per();
    int cnt;
    clr = 1; note_per = 15'd1; note_dur = 8'd2;
    cyc();
    clr = 0;
    for (int i = 1; i <= 45; i++) begin
      if (i == 25) note_per = 15'd0;
      cyc();
      checks++;
      if ({piezo, piezo_n, note_over} !== {e_p, e_pn, e_o}) begin
        errors++;
        $display("FAIL short_per cyc %0d: got piezo/piezo_n/note_over=%b%b%b expected %b%b%b", i - 1, piezo, piezo_n, note_over, e_p, e_pn, e_o);
      end
    end
    clr = 1; cyc();
    clr = 0; note_per = 15'd10; note_dur = 8'd0;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (note_over) cnt++;
      if ({piezo, piezo_n} !== {e_p, e_pn}) begin
        errors++;
        $display("FAIL dur0 tone cyc %0d: got piezo/piezo_n=%b%b expected %b%b", i, piezo, piezo_n, e_p, e_pn);
      end
    end
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL dur0_pulses: got %0d note_over pulses expected 0", cnt);
    end
  endtask

  task automatic test_async_reset();
    int first;
    clr = 1; note_per = 15'd8; note_dur = 8'd2;
    cyc();
    clr = 0;
    for (int i = 0; i < 14; i++) cyc();
    #2 rst_n = 0;
    #1;
    checks++;
    if ({piezo, piezo_n, note_over} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: got piezo/piezo_n/note_over=%b%b%b expected 000", piezo, piezo_n, note_over);
    end
    cyc(); cyc();
    @(negedge clk);
    rst_n = 1;
    first = -1;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      checks++;
      if ({piezo, piezo_n, note_over} !== {e_p, e_pn, e_o}) begin
        errors++;
        $display("FAIL after_reset cyc %0d: got piezo/piezo_n/note_over=%b%b%b expected %b%b%b", i - 1, piezo, piezo_n, note_over, e_p, e_pn, e_o);
      end
      if (note_over && first < 0) first = i - 1;
    end
    checks++;
    if (first != 20) begin
      errors++;
      $display("FAIL after_reset_pulse: got first pulse at cycle %0d expected 20", first);
    end
  endtask

  task automatic test_random();
    clr = 1; cyc();
    clr = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) note_per = 15'($urandom_range(0, 20));
      if ($urandom_range(0, 59) == 0) note_dur = 8'($urandom_range(0, 4));
      clr = ($urandom_range(0, 49) == 0);
      cyc();
      checks++;
      if ({piezo, piezo_n, note_over} !== {e_p, e_pn, e_o}) begin
        errors++;
        $display("FAIL random cyc %0d: got piezo/piezo_n/note_over=%b%b%b expected %b%b%b (per=%0d dur=%0d)", i, piezo, piezo_n, note_over, e_p, e_pn, e_o, note_per, note_dur);
      end
    end
  endtask

  initial begin
    m_play = 0; m_n = 0; m_p = 0;
    e_p = 0; e_pn = 0; e_o = 0;
    test_reset();
    test_tone();
    test_retune();
    test_clr_mid();
    test_short_per();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
